// File: rtl/request_encoder_if.sv
// Handshake bundle for the request encoder: eight request lines, mask and ack in,
// encoded vector, valid, pending and multi out.
interface request_encoder_if;
   logic       d7, d6, d5, d4, d3, d2, d1, d0;
   logic [7:0] mask;
   logic       ack;
   logic       vector2, vector1, vector0;
   logic       valid;
   logic [7:0] pending;
   logic       multi;

   modport master (
      output d7, d6, d5, d4, d3, d2, d1, d0, mask, ack,
      input  vector2, vector1, vector0, valid, pending, multi
   );

   modport slave (
      input  d7, d6, d5, d4, d3, d2, d1, d0, mask, ack,
      output vector2, vector1, vector0, valid, pending, multi
   );
endinterface

// File: rtl/request_encoder.sv
// Sequential 8-to-3 priority encoder: latches request lines into a pending register and
// presents the highest-priority unmasked pending index with a valid/ack handshake.
module request_encoder #(
   parameter bit HIGH_FIRST = 1'b1
) (
   input logic              clk,
   input logic              reset,
   request_encoder_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nx;
   logic [7:0] pending, pending_nx;
   logic [7:0] req, eligible, clr;
   logic [2:0] vector, vector_nx, pick;
   logic       multi, multi_nx;

   assign req      = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
   assign eligible = pending & bus.mask;

   // Later loop iterations overwrite earlier ones, so the last eligible index visited wins.
   always_comb begin
      pick = 3'd0;
      if (HIGH_FIRST) begin
         for (int i = 0; i < 8; i++)
            if (eligible[i]) pick = 3'(i);
      end else begin
         for (int i = 7; i >= 0; i--)
            if (eligible[i]) pick = 3'(i);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nx  = state;
      vector_nx = vector;
      multi_nx  = multi;
      clr       = 8'h00;
      case (state)
         IDLE: begin
            if (eligible != 8'h00) begin
               vector_nx = pick;
               multi_nx  = |(eligible & (eligible - 8'd1));
               state_nx  = GRANT;
            end
         end
         GRANT: begin
            if (bus.ack) begin
               clr[vector] = 1'b1;
               state_nx    = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A request arriving on the ack edge re-sets the bit being cleared.
      pending_nx = (pending & ~clr) | req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pending <= 8'h00;
         vector  <= 3'd0;
         multi   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         state   <= state_nx;
         pending <= pending_nx;
         vector  <= vector_nx;
         multi   <= multi_nx;
      end
   end

   assign bus.vector2 = vector[2];
   assign bus.vector1 = vector[1];
   assign bus.vector0 = vector[0];
   assign bus.valid   = (state == GRANT);
   assign bus.pending = pending;
   assign bus.multi   = multi;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: both priority orders side by side, directed scenarios with
// literal expectations, then random traffic checked every cycle against a behavioural model.
module tb_request_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] d_drv = 8'h00;
   logic [7:0] mask_drv = 8'hFF;
   logic       ack_drv = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   request_encoder_if bus0 ();
   request_encoder_if bus1 ();

   assign {bus0.d7, bus0.d6, bus0.d5, bus0.d4, bus0.d3, bus0.d2, bus0.d1, bus0.d0} = d_drv;
   assign {bus1.d7, bus1.d6, bus1.d5, bus1.d4, bus1.d3, bus1.d2, bus1.d1, bus1.d0} = d_drv;
   assign bus0.mask = mask_drv;
   assign bus1.mask = mask_drv;
   assign bus0.ack  = ack_drv;
   assign bus1.ack  = ack_drv;

   request_encoder #(.HIGH_FIRST(1'b1)) u_hi (.clk(clk), .reset(reset), .bus(bus0.slave));
   request_encoder #(.HIGH_FIRST(1'b0)) u_lo (.clk(clk), .reset(reset), .bus(bus1.slave));

   logic [2:0] vec0, vec1;
   assign vec0 = {bus0.vector2, bus0.vector1, bus0.vector0};
   assign vec1 = {bus1.vector2, bus1.vector1, bus1.vector0};

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [7:0] pend;
      logic       valid;
      logic [2:0] vec;
      logic       multi;
   } mstate_t;

   mstate_t m0 = '0;
   mstate_t m1 = '0;

   function automatic mstate_t step(mstate_t s, logic [7:0] d, logic [7:0] m, logic a, bit hf);
      mstate_t    r  = s;
      logic [7:0] el = s.pend & m;
      if (s.valid) begin
         if (a) begin
            r.valid     = 1'b0;
            r.pend[s.vec] = 1'b0;
         end
      end else if (el != 8'h00) begin
         r.valid = 1'b1;
         r.multi = ($countones(el) > 1);
         for (int k = 0; k < 8; k++) begin
            int i = hf ? 7 - k : k;
            if (el[i]) begin
               r.vec = 3'(i);
               break;
            end
         end
      end
      r.pend = r.pend | d;
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m0 <= '0;
         m1 <= '0;
      end else begin
         m0 <= step(m0, d_drv, mask_drv, ack_drv, 1'b1);
         m1 <= step(m1, d_drv, mask_drv, ack_drv, 1'b0);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_out(input string tag, input mstate_t m, input logic [7:0] pend,
                              input logic valid, input logic [2:0] vec, input logic multi);
      check({tag, ".pending"}, 32'(pend), 32'(m.pend));
      check({tag, ".valid"},   32'(valid), 32'(m.valid));
      check({tag, ".vector"},  32'(vec), 32'(m.vec));
      check({tag, ".multi"},   32'(multi), 32'(m.multi));
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         compare_out("model_hi", m0, bus0.pending, bus0.valid, vec0, bus0.multi);
         compare_out("model_lo", m1, bus1.pending, bus1.valid, vec1, bus1.multi);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      #2;
      check("rst.pending", 32'(bus0.pending), 32'h00);
      check("rst.valid",   32'(bus0.valid), 32'h0);
      check("rst.vector",  32'(vec0), 32'h0);
      check("rst.multi",   32'(bus0.multi), 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // 1: single pulse on d5
      d_drv = 8'h20;
      tick();
      check("t1.pending_e1", 32'(bus0.pending), 32'h20);
      check("t1.valid_e1",   32'(bus0.valid), 32'h0);
      d_drv = 8'h00;
      tick();
      check("t1.vector", 32'(vec0), 32'h5);
      check("t1.valid",  32'(bus0.valid), 32'h1);
      check("t1.multi",  32'(bus0.multi), 32'h0);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      check("t1.valid_ack",   32'(bus0.valid), 32'h0);
      check("t1.pending_ack", 32'(bus0.pending), 32'h00);
      tick();

      // 2: d6 and d2 together, ack each grant at once
      d_drv = 8'h44;
      tick();
      d_drv = 8'h00;
      tick();
      check("t2.vec_first",   32'(vec0), 32'h6);
      check("t2.multi_first", 32'(bus0.multi), 32'h1);
      check("t2.lo_vec_first", 32'(vec1), 32'h2);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      check("t2.idle_gap", 32'(bus0.valid), 32'h0);
      tick();
      check("t2.valid_second", 32'(bus0.valid), 32'h1);
      check("t2.vec_second",   32'(vec0), 32'h2);
      check("t2.multi_second", 32'(bus0.multi), 32'h0);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();
      check("t2.valid_done", 32'(bus0.valid), 32'h0);
      check("t2.pend_done",  32'(bus0.pending), 32'h00);

      // 3: low-first order with pending = 81
      d_drv = 8'h81;
      tick();
      d_drv = 8'h00;
      tick();
      check("t3.lo_first",  32'(vec1), 32'h0);
      check("t3.hi_first",  32'(vec0), 32'h7);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();
      check("t3.lo_second", 32'(vec1), 32'h7);
      check("t3.lo_valid2", 32'(bus1.valid), 32'h1);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();

      // 4: masked line waits until unmasked
      mask_drv = 8'hF7;
      d_drv    = 8'h08;
      tick();
      d_drv = 8'h00;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("t4.masked_valid", 32'(bus0.valid), 32'h0);
         check("t4.masked_pend",  32'(bus0.pending), 32'h08);
      end
      mask_drv = 8'hFF;
      tick();
      tick();
      check("t4.unmask_valid", 32'(bus0.valid), 32'h1);
      check("t4.unmask_vec",   32'(vec0), 32'h3);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();

      // 5: set wins over clear on the ack edge; ack while idle is ignored
      d_drv = 8'h10;
      tick();
      d_drv = 8'h00;
      tick();
      check("t5.vec", 32'(vec0), 32'h4);
      ack_drv = 1'b1;
      d_drv   = 8'h10;
      tick();
      ack_drv = 1'b0;
      d_drv   = 8'h00;
      check("t5.setwins_pend",  32'(bus0.pending[4]), 32'h1);
      check("t5.setwins_valid", 32'(bus0.valid), 32'h0);
      tick();
      check("t5.regrant_valid", 32'(bus0.valid), 32'h1);
      check("t5.regrant_vec",   32'(vec0), 32'h4);
      ack_drv = 1'b1;
      tick();
      ack_drv  = 1'b0;
      mask_drv = 8'hEF;
      d_drv    = 8'h10;
      tick();
      d_drv   = 8'h00;
      ack_drv = 1'b1;
      tick();
      tick();
      check("t5.idle_ack_pend",  32'(bus0.pending), 32'h10);
      check("t5.idle_ack_valid", 32'(bus0.valid), 32'h0);
      ack_drv  = 1'b0;
      mask_drv = 8'hFF;
      tick();
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();

      // 6: asynchronous reset in the middle of a grant
      d_drv = 8'hFF;
      tick();
      d_drv = 8'h00;
      tick();
      check("t6.pre_vec",  32'(vec0), 32'h7);
      check("t6.pre_pend", 32'(bus0.pending), 32'hFF);
      #1 reset = 1'b1;
      #1;
      check("t6.async_valid", 32'(bus0.valid), 32'h0);
      check("t6.async_vec",   32'(vec0), 32'h0);
      check("t6.async_multi", 32'(bus0.multi), 32'h0);
      check("t6.async_pend",  32'(bus0.pending), 32'h00);
      tick();
      #2 reset = 1'b0;
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t6.post_valid", 32'(bus0.valid), 32'h0);
         check("t6.post_pend",  32'(bus0.pending), 32'h00);
      end

      // Random traffic, checked every cycle by the model compare
      for (int c = 0; c < 4000; c++) begin
         d_drv    = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
         mask_drv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
         ack_drv  = 1'($urandom_range(0, 1));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
